// File: rtl/med_pkg.sv
// Shared types and constants for the medicine-schedule table controller.
package med_pkg;

  localparam int unsigned MED_ID_W   = 4;
  localparam int unsigned MED_FREQ_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } state_e;

  localparam logic WR_STORE  = 1'b0;
  localparam logic WR_DELETE = 1'b1;

endpackage

// File: rtl/med_table_mem.sv
// Valid-bit vector plus frequency array: one write port, asynchronous reads,
// and a per-entry clear port used by the table sweep.
module med_table_mem
  import med_pkg::*;
#(
  parameter int unsigned ID_W   = MED_ID_W,
  parameter int unsigned FREQ_W = MED_FREQ_W
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wr_En,
  input  logic              Wr_Del,
  input  logic [ID_W-1:0]   Wr_ID,
  input  logic [FREQ_W-1:0] Wr_Freq,
  input  logic              Clr_En,
  input  logic [ID_W-1:0]   Clr_ID,
  input  logic [ID_W-1:0]   Rd_ID,
  output logic              Rd_Vld_c,
  output logic [FREQ_W-1:0] Rd_Freq_c,
  output logic              Wr_Vld_c
);

  localparam int unsigned DEPTH = 2 ** ID_W;

  logic [DEPTH-1:0]  valid_q;
  logic [FREQ_W-1:0] freq_q [DEPTH];

  // Clear and write never coincide: writes are blocked while sweeping.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      valid_q <= '0;
    end else begin
      if (Clr_En) valid_q[Clr_ID] <= 1'b0;
      if (Wr_En)  valid_q[Wr_ID]  <= (Wr_Del == WR_STORE);
    end
  end

  // Frequency storage is deliberately left out of reset.
  always_ff @(posedge Clk) begin
    if (Wr_En && (Wr_Del == WR_STORE)) freq_q[Wr_ID] <= Wr_Freq;
  end

  assign Rd_Vld_c  = valid_q[Rd_ID];
  assign Rd_Freq_c = freq_q[Rd_ID];
  assign Wr_Vld_c  = valid_q[Wr_ID];

endmodule

// File: rtl/med_table_ctrl.sv
// Medicine-schedule table controller: write/delete and read ports, occupancy
// count and swept clear. Define MED_TABLE_RD_BYPASS_EN for same-ID write-to-read bypass.
module med_table_ctrl
  import med_pkg::*;
#(
  parameter int unsigned ID_W   = MED_ID_W,
  parameter int unsigned FREQ_W = MED_FREQ_W,
  parameter int unsigned CNT_W  = ID_W + 1
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Wr_En,
  input  logic              Wr_Del,
  input  logic [ID_W-1:0]   Wr_ID,
  input  logic [FREQ_W-1:0] Wr_Freq,
  input  logic              Rd_En,
  input  logic [ID_W-1:0]   Rd_ID,
  output logic              Rd_Valid,
  output logic              Rd_Hit,
  output logic [FREQ_W-1:0] Rd_Freq,
  output logic [ID_W-1:0]   Rd_ID_Out,
  input  logic              Clr_Req,
  output logic              Busy,
  output logic [CNT_W-1:0]  Entry_Count,
  output logic              Full
);

  localparam int unsigned       DEPTH   = 2 ** ID_W;
  localparam logic [ID_W-1:0]   LAST_ID = ID_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

  state_e            state;
  logic [ID_W-1:0]   sweep_ptr;
  logic              open_c, wr_acc_c, rd_acc_c, sweep_c;
  logic              wr_vld_c, rd_vld_c;
  logic [FREQ_W-1:0] rd_freq_c;
  logic              hit_c;
  logic [FREQ_W-1:0] freq_c;
  logic [CNT_W-1:0]  cnt_inc_c;

  // Ports are only serviced in IDLE and not in the cycle a clear is accepted.
  assign open_c    = (state == IDLE) && !Clr_Req;
  assign wr_acc_c  = open_c && Wr_En;
  assign rd_acc_c  = open_c && Rd_En;
  assign sweep_c   = (state == SWEEP);
  assign cnt_inc_c = Entry_Count + CNT_W'(1);

  med_table_mem #(
    .ID_W   (ID_W),
    .FREQ_W (FREQ_W)
  ) u_mem (
    .Clk       (Clk),
    .Rst       (Rst),
    .Wr_En     (wr_acc_c),
    .Wr_Del    (Wr_Del),
    .Wr_ID     (Wr_ID),
    .Wr_Freq   (Wr_Freq),
    .Clr_En    (sweep_c),
    .Clr_ID    (sweep_ptr),
    .Rd_ID     (Rd_ID),
    .Rd_Vld_c  (rd_vld_c),
    .Rd_Freq_c (rd_freq_c),
    .Wr_Vld_c  (wr_vld_c)
  );

  // Lookup result; optionally forwards a same-cycle write to the same ID.
  always_comb begin
    hit_c  = rd_vld_c;
    freq_c = rd_vld_c ? rd_freq_c : '0;
`ifdef MED_TABLE_RD_BYPASS_EN
    if (wr_acc_c && (Wr_ID == Rd_ID)) begin
      hit_c  = (Wr_Del == WR_STORE);
      freq_c = (Wr_Del == WR_STORE) ? Wr_Freq : '0;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state       <= IDLE;
      sweep_ptr   <= '0;
      Busy        <= 1'b0;
      Entry_Count <= '0;
      Full        <= 1'b0;
      Rd_Valid    <= 1'b0;
      Rd_Hit      <= 1'b0;
      Rd_Freq     <= '0;
      Rd_ID_Out   <= '0;
    end else begin
      Rd_Valid <= rd_acc_c;
      if (rd_acc_c) begin
        Rd_Hit    <= hit_c;
        Rd_Freq   <= freq_c;
        Rd_ID_Out <= Rd_ID;
      end

      case (state)
        IDLE: begin
          if (Clr_Req) begin
            state     <= SWEEP;
            sweep_ptr <= '0;
            Busy      <= 1'b1;
          end else if (wr_acc_c) begin
            // Count tracks valid-bit transitions only.
            if ((Wr_Del == WR_STORE) && !wr_vld_c) begin
              Entry_Count <= cnt_inc_c;
              Full        <= (cnt_inc_c == FULL_CNT);
            end else if ((Wr_Del == WR_DELETE) && wr_vld_c) begin
              Entry_Count <= Entry_Count - CNT_W'(1);
              Full        <= 1'b0;
            end
          end
        end
        SWEEP: begin
          if (sweep_ptr == LAST_ID) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            Entry_Count <= '0;
            Full        <= 1'b0;
          end else begin
            sweep_ptr <= sweep_ptr + ID_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_med_table_ctrl.sv
// Self-checking bench for med_table_ctrl: directed vector table, corner-case
// sequences and randomized traffic against a behavioural table model.
module tb_med_table_ctrl;

  localparam int DEPTH = 16;

  logic       Clk = 1'b0;
  logic       Rst, Wr_En, Wr_Del, Rd_En, Clr_Req;
  logic [3:0] Wr_ID, Wr_Freq, Rd_ID;
  logic       Rd_Valid, Rd_Hit, Busy, Full;
  logic [3:0] Rd_Freq, Rd_ID_Out;
  logic [4:0] Entry_Count;

  med_table_ctrl dut (
    .Clk         (Clk),
    .Rst         (Rst),
    .Wr_En       (Wr_En),
    .Wr_Del      (Wr_Del),
    .Wr_ID       (Wr_ID),
    .Wr_Freq     (Wr_Freq),
    .Rd_En       (Rd_En),
    .Rd_ID       (Rd_ID),
    .Rd_Valid    (Rd_Valid),
    .Rd_Hit      (Rd_Hit),
    .Rd_Freq     (Rd_Freq),
    .Rd_ID_Out   (Rd_ID_Out),
    .Clr_Req     (Clr_Req),
    .Busy        (Busy),
    .Entry_Count (Entry_Count),
    .Full        (Full)
  );

  always #5 Clk = ~Clk;

  int n_pass = 0;
  int n_total = 0;

  // Behavioural model: a plain table plus a remaining-sweep-cycles counter.
  bit m_valid [DEPTH];
  int m_freq_a [DEPTH];
  int m_sweep = 0;
  bit m_rv = 0, m_hit = 0;
  int m_freq = 0, m_id = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int occupancy();
    int s = 0;
    for (int i = 0; i < DEPTH; i++) s += int'(m_valid[i]);
    return s;
  endfunction

  task automatic idle_inputs();
    Rst = 0; Wr_En = 0; Wr_Del = 0; Wr_ID = 0; Wr_Freq = 0;
    Rd_En = 0; Rd_ID = 0; Clr_Req = 0;
  endtask

  // Update the model from the inputs about to be clocked, clock, then compare.
  task automatic tick();
    bit idle, acc;
    idle = (m_sweep == 0);
    acc  = idle && !Clr_Req;
    if (Rst) begin
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      m_sweep = 0; m_rv = 0; m_hit = 0; m_freq = 0; m_id = 0;
    end else begin
      m_rv = acc && Rd_En;
      if (m_rv) begin
        m_id   = int'(Rd_ID);
        m_hit  = m_valid[Rd_ID];
        m_freq = m_hit ? m_freq_a[Rd_ID] : 0;
`ifdef MED_TABLE_RD_BYPASS_EN
        if (Wr_En && Wr_ID == Rd_ID) begin
          m_hit  = !Wr_Del;
          m_freq = Wr_Del ? 0 : int'(Wr_Freq);
        end
`endif
      end
      if (acc && Wr_En) begin
        m_valid[Wr_ID] = !Wr_Del;
        if (!Wr_Del) m_freq_a[Wr_ID] = int'(Wr_Freq);
      end
      if (idle && Clr_Req) m_sweep = DEPTH;
      else if (!idle) begin
        m_sweep--;
        if (m_sweep == 0) for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      end
    end
    @(posedge Clk); #1;
    chk("model.rd_valid", int'(Rd_Valid), int'(m_rv));
    chk("model.rd_hit", int'(Rd_Hit), int'(m_hit));
    chk("model.rd_freq", int'(Rd_Freq), m_freq);
    chk("model.rd_id_out", int'(Rd_ID_Out), m_id);
    chk("model.busy", int'(Busy), int'(m_sweep > 0));
    chk("model.count", int'(Entry_Count), occupancy());
    chk("model.full", int'(Full), int'(occupancy() == DEPTH));
  endtask

  task automatic wr(input int id, input int f, input bit del);
    idle_inputs(); Wr_En = 1; Wr_ID = 4'(id); Wr_Freq = 4'(f); Wr_Del = del; tick();
  endtask

  task automatic rd(input int id);
    idle_inputs(); Rd_En = 1; Rd_ID = 4'(id); tick();
  endtask

  typedef struct {
    bit rst; bit wr_en; bit wr_del; int wr_id; int wr_freq;
    bit rd_en; int rd_id; bit clr;
    bit e_rv; bit e_hit; int e_freq; int e_id; int e_cnt; bit e_full;
  } vec_t;

  vec_t vecs [14];
  int   busy_cycles;

  initial begin
    for (int i = 0; i < DEPTH; i++) begin m_valid[i] = 0; m_freq_a[i] = 0; end
    idle_inputs();

    //            rst we del id f  re rid clr  rv hit f id cnt full
    vecs[0]  = '{1, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[1]  = '{0, 0, 0, 0, 0, 1, 3, 0,   1, 0, 0, 3, 0, 0};
    vecs[2]  = '{0, 1, 0, 5, 9, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[3]  = '{0, 0, 0, 0, 0, 1, 5, 0,   1, 1, 9, 5, 1, 0};
    vecs[4]  = '{0, 1, 0, 5, 2, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[5]  = '{0, 0, 0, 0, 0, 1, 5, 0,   1, 1, 2, 5, 1, 0};
    vecs[6]  = '{0, 1, 1, 5, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0};
    vecs[7]  = '{0, 0, 0, 0, 0, 1, 5, 0,   1, 0, 0, 5, 0, 0};
    vecs[8]  = '{0, 1, 0, 1, 3, 0, 0, 0,   0, 0, 0, 0, 1, 0};
    vecs[9]  = '{0, 1, 0, 3, 6, 0, 0, 0,   0, 0, 0, 0, 2, 0};
    vecs[10] = '{0, 1, 0, 4, 7, 0, 0, 0,   0, 0, 0, 0, 3, 0};
    vecs[11] = '{0, 1, 1, 2, 0, 0, 0, 0,   0, 0, 0, 0, 3, 0};
    vecs[12] = '{0, 0, 0, 0, 0, 1, 4, 0,   1, 1, 7, 4, 3, 0};
    vecs[13] = '{0, 1, 1, 3, 0, 1, 3, 0,   1, 1, 6, 3, 2, 0};

    for (int i = 0; i < 14; i++) begin
      Rst = vecs[i].rst; Wr_En = vecs[i].wr_en; Wr_Del = vecs[i].wr_del;
      Wr_ID = 4'(vecs[i].wr_id); Wr_Freq = 4'(vecs[i].wr_freq);
      Rd_En = vecs[i].rd_en; Rd_ID = 4'(vecs[i].rd_id); Clr_Req = vecs[i].clr;
      tick();
      chk($sformatf("vec%0d.rd_valid", i), int'(Rd_Valid), int'(vecs[i].e_rv));
      if (vecs[i].e_rv) begin
        chk($sformatf("vec%0d.rd_hit", i), int'(Rd_Hit), int'(vecs[i].e_hit));
        chk($sformatf("vec%0d.rd_freq", i), int'(Rd_Freq), vecs[i].e_freq);
        chk($sformatf("vec%0d.rd_id_out", i), int'(Rd_ID_Out), vecs[i].e_id);
      end
      chk($sformatf("vec%0d.count", i), int'(Entry_Count), vecs[i].e_cnt);
      chk($sformatf("vec%0d.full", i), int'(Full), int'(vecs[i].e_full));
    end

    // Same-cycle write and read of ID 7 on an empty table.
    idle_inputs(); Rst = 1; tick();
    idle_inputs(); Wr_En = 1; Wr_ID = 7; Wr_Freq = 4; Rd_En = 1; Rd_ID = 7; tick();
`ifdef MED_TABLE_RD_BYPASS_EN
    chk("same_id.hit", int'(Rd_Hit), 1);
    chk("same_id.freq", int'(Rd_Freq), 4);
`else
    chk("same_id.hit", int'(Rd_Hit), 0);
    chk("same_id.freq", int'(Rd_Freq), 0);
`endif
    chk("same_id.count", int'(Entry_Count), 1);

    // Fill the table, then clear with a simultaneous (ignored) delete.
    for (int i = 0; i < DEPTH; i++) wr(i, i ^ 5, 0);
    chk("fill.count", int'(Entry_Count), 16);
    chk("fill.full", int'(Full), 1);
    idle_inputs(); Clr_Req = 1; Wr_En = 1; Wr_Del = 1; Wr_ID = 0; tick();
    chk("clr_accept.busy", int'(Busy), 1);
    chk("clr_accept.count", int'(Entry_Count), 16);
    busy_cycles = 1;
    for (int k = 0; k < 40 && Busy; k++) begin
      idle_inputs();
      Wr_En = 1; Wr_Del = 1'($urandom); Wr_ID = 4'($urandom); Wr_Freq = 4'($urandom);
      Rd_En = 1; Rd_ID = 4'($urandom); Clr_Req = 1'($urandom);
      tick();
      if (Busy) busy_cycles++;
      chk("sweep.no_rd_valid", int'(Rd_Valid), 0);
    end
    chk("sweep.busy_cycles", busy_cycles, 16);
    chk("sweep.count", int'(Entry_Count), 0);
    chk("sweep.full", int'(Full), 0);
    for (int i = 0; i < DEPTH; i++) begin
      rd(i);
      chk("after_sweep.hit", int'(Rd_Hit), 0);
    end

    // Back-to-back reads to alternating IDs.
    wr(1, 3, 0);
    for (int i = 0; i < 8; i++) begin
      rd((i % 2 == 0) ? 1 : 9);
      chk("b2b.rd_valid", int'(Rd_Valid), 1);
      chk("b2b.id_out", int'(Rd_ID_Out), (i % 2 == 0) ? 1 : 9);
    end
    idle_inputs(); tick();
    chk("b2b.drop", int'(Rd_Valid), 0);

    // Reset in the middle of a sweep.
    wr(4, 8, 0); wr(6, 2, 0);
    idle_inputs(); Clr_Req = 1; tick();
    idle_inputs();
    for (int i = 0; i < 5; i++) tick();
    Rst = 1; tick();
    chk("mid_rst.busy", int'(Busy), 0);
    chk("mid_rst.count", int'(Entry_Count), 0);
    rd(4);
    chk("mid_rst.miss", int'(Rd_Hit), 0);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      idle_inputs();
      Rst     = ($urandom_range(0, 299) == 0);
      Clr_Req = ($urandom_range(0, 79) == 0);
      Wr_En   = 1'($urandom);
      Wr_Del  = ($urandom_range(0, 3) == 0);
      Wr_ID   = 4'($urandom);
      Wr_Freq = 4'($urandom);
      Rd_En   = 1'($urandom);
      Rd_ID   = ($urandom_range(0, 3) == 0) ? Wr_ID : 4'($urandom);
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/med_table_ctrl.md
Name: med_table_ctrl

Overview:
- Parametrised medicine-schedule table controller; next generation of the single-entry RAM1 write/read controller.
- Owns an internal table indexed by medicine ID. Each entry holds a valid bit and a frequency.
- Provides independent write/delete and read ports, registered read response with hit/miss, live occupancy count, and a swept table clear.
- Sits between the keypad/command decoder (writes) and the reminder scheduler (reads).

Parameters:
- ID_W, 4, medicine ID width; table depth = 2**ID_W entries.
- FREQ_W, 4, frequency field width.
- CNT_W, ID_W+1, width of Entry_Count; must hold 0..2**ID_W.

Ports:
- Clk  in  1  clock; all logic on posedge.
- Rst  in  1  synchronous active-high reset.
- Wr_En  in  1  write/delete strobe, single-cycle.
- Wr_Del  in  1  qualifies Wr_En: 1 = invalidate entry, 0 = store Wr_Freq.
- Wr_ID  in  ID_W  entry address for the write.
- Wr_Freq  in  FREQ_W  frequency to store.
- Rd_En  in  1  read strobe.
- Rd_ID  in  ID_W  entry address for the read.
- Rd_Valid  out  1  response strobe, one cycle, exactly 1 cycle after an accepted Rd_En.
- Rd_Hit  out  1  entry valid at lookup.
- Rd_Freq  out  FREQ_W  stored frequency; 0 on miss.
- Rd_ID_Out  out  ID_W  echo of the looked-up ID.
- Clr_Req  in  1  start table clear.
- Busy  out  1  clear sweep in progress.
- Entry_Count  out  CNT_W  number of valid entries.
- Full  out  1  Entry_Count == 2**ID_W.

Behaviour:
- Reset (Rst=1 at posedge):
  - All valid bits 0, Entry_Count 0, Full 0.
  - Rd_Valid, Rd_Hit, Rd_Freq, Rd_ID_Out all 0. Busy 0. FSM returns to IDLE.
  - Frequency storage is not cleared.
  - Reset mid-sweep aborts the sweep; the result is still a fully empty table.
- FSM states:
  - IDLE: Clr_Req=1 -> SWEEP with sweep pointer 0, Busy=1 from the next cycle.
  - SWEEP: clears the valid bit at the pointer each cycle and increments the pointer. At pointer 2**ID_W-1, clears that entry and goes to IDLE. The sweep takes exactly 2**ID_W cycles.
  - At sweep end: Entry_Count = 0, Busy = 0.
  - Clr_Req while in SWEEP is ignored.
- While Busy=1 (and in the cycle Clr_Req is accepted): Wr_En and Rd_En are ignored, there is no Rd_Valid, and counters are unchanged. Callers must sample Busy.
- Write, when accepted:
  - Wr_Del=0 sets valid and stores the frequency.
  - Wr_Del=1 clears valid; the frequency is untouched.
  - Entry_Count +1 only on an invalid->valid transition, -1 only on valid->invalid. Overwriting a valid entry or deleting an invalid one leaves the count unchanged.
  - Full is registered alongside the count. Writes to a new ID while Full cannot occur, because depth equals the ID space.
- Read:
  - Lookup uses the table state before any same-cycle write (default; see Optional Feature).
  - On the next cycle: Rd_Valid=1, Rd_ID_Out=Rd_ID, Rd_Hit=valid[Rd_ID], Rd_Freq = hit ? freq : 0.
  - Rd_Valid drops to 0 the cycle after it is asserted unless another read is accepted.
  - Rd_Hit, Rd_Freq and Rd_ID_Out hold their last values when Rd_Valid=0.
- Reads and writes are fully concurrent, including to the same ID. Back-to-back reads every cycle give a response every cycle.
- Widths: Freq stored exactly FREQ_W bits. No arithmetic other than the count and the pointer; the pointer stops at its last value, with no wrap-around into a second sweep.

Optional Feature:
- Macro: MED_TABLE_RD_BYPASS_EN.
- Defined: when a Wr_En and an Rd_En to the same ID are accepted in the same cycle, the read response reflects the write. A store gives Hit=1 with Freq=Wr_Freq; a delete gives Hit=0 with Freq=0.
- Undefined: the response reflects the pre-write contents.
- No other behaviour differs.

Decomposition:
- Package med_pkg holds: ID_W/FREQ_W defaults, FSM state enum (IDLE, SWEEP), and the Wr_Del encoding constants (WR_STORE=0, WR_DELETE=1).
- One sub-module, med_table_mem: valid-bit vector plus frequency array, with a write port, an asynchronous read port, and a per-entry clear port driven by the sweep.
- Counter, FSM and response register stay in med_table_ctrl.

Test Plan:
- Reset then Rd_En ID=3 -> next cycle Rd_Valid=1, Hit=0, Freq=0, ID_Out=3; Entry_Count=0.
- Write ID=5 Freq=9, then read ID=5 -> Hit=1, Freq=9, count=1. Rewrite ID=5 Freq=2 -> count stays 1, read gives 2. Delete ID=5 -> count 0, read misses.
- Write all 16 IDs -> Full=1, count=16. Clr_Req -> Busy high for exactly 16 cycles; Wr_En/Rd_En during the sweep are ignored with no Rd_Valid. After the sweep: count 0, Full 0, all reads miss.
- Same-cycle write ID=7 Freq=4 and read ID=7 on an empty table -> Hit=0, Freq=0 without the macro; Hit=1, Freq=4 with MED_TABLE_RD_BYPASS_EN.
- Reads on 8 consecutive cycles to alternating IDs -> 8 consecutive Rd_Valid cycles with matching ID_Out. Rst asserted mid-sweep -> Busy=0 next cycle and the table is empty.
- Delete on an invalid ID=2 with count=3 -> count stays 3; simultaneous Clr_Req and Wr_En -> write ignored, sweep starts.
